// File: rtl/drum_pkg.sv
// drum_pkg: shared state type, step-width helper and sustain width for the drum sequencer
package drum_pkg;

    typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_state_t;

    localparam int SUSTAIN_W = 8;

    function automatic int step_w(input int steps);
        return $clog2(steps);
    endfunction

endpackage

// File: rtl/drum_sequencer_step_timer.sv
// step_timer: per-step tick counter; pulses advance on the last tick of each step
module step_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    input  logic [TW-1:0] tempo_div,
    output logic          advance
);

    logic [TW-1:0] tick_q, tick_d, last_tick;

    // a divider of 0 behaves as 1; >= lets a lowered divider advance at once
    always_comb begin
        last_tick = (tempo_div == '0) ? '0 : tempo_div - TW'(1);
        advance   = enable && (tick_q >= last_tick);
        tick_d    = clear ? '0 : !enable ? tick_q : advance ? '0 : tick_q + TW'(1);
    end

    // tick register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick_q <= '0;
        else       tick_q <= tick_d;
    end

endmodule

// File: rtl/drum_sequencer.sv
// drum_sequencer: 16-step hit sequencer driving the ADSR start trigger; DRUM_SEQ_ACCENT_EN adds per-step sustain accent
module drum_sequencer
    import drum_pkg::*;
#(
    parameter int STEPS  = 16,
    parameter int TW     = 16,
    parameter int RETRIG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic [STEPS-1:0]           pattern_in,
    input  logic                       pattern_load,
    input  logic [TW-1:0]              tempo_div,
    input  logic                       adsr_idle,
`ifdef DRUM_SEQ_ACCENT_EN
    input  logic [STEPS-1:0]           accent_in,
    input  logic [SUSTAIN_W-1:0]       sustain_normal,
    input  logic [SUSTAIN_W-1:0]       sustain_accent,
    output logic [SUSTAIN_W-1:0]       sustain_level_out,
`endif
    output logic                       start,
    output logic [step_w(STEPS)-1:0]   step,
    output logic                       step_strobe,
    output logic                       hit_dropped,
    output logic                       running
);

    localparam int SW = step_w(STEPS);
`ifdef DRUM_SEQ_ACCENT_EN
    localparam int PW = 2 * STEPS;
`else
    localparam int PW = STEPS;
`endif

    seq_state_t    state_q, state_d;
    logic [SW-1:0] step_q, step_d, next_step;
    logic [PW-1:0] active_q, active_d, shadow_q, shadow_d, load_word;
    logic          pending_q, pending_d;
    logic          start_q, start_d, strobe_q, strobe_d, drop_q, drop_d;
    logic          advance, timer_en, hit, accept;

`ifdef DRUM_SEQ_ACCENT_EN
    logic [SUSTAIN_W-1:0] sustain_q, sustain_d;
    assign load_word = {accent_in, pattern_in};
`else
    assign load_word = pattern_in;
`endif

    assign timer_en = (state_q == SEQ_RUN) && run;

    step_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .enable   (timer_en),
        .clear    (!timer_en),
        .tempo_div(tempo_div),
        .advance  (advance)
    );

    // run/idle control, pattern double-buffering and hit qualification for the step being entered
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        strobe_d  = 1'b0;
        next_step = step_q + SW'(1);
        if (state_q == SEQ_IDLE) begin
            if (pattern_load) begin
                active_d  = load_word;
                pending_d = 1'b0;
            end else if (run && pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
            if (run) begin
                state_d  = SEQ_RUN;
                step_d   = '0;
                strobe_d = 1'b1;
            end
        end else begin
            if (pattern_load) begin
                shadow_d  = load_word;
                pending_d = 1'b1;
            end
            if (!run) begin
                state_d = SEQ_IDLE;
                step_d  = '0;
            end else if (advance) begin
                step_d   = next_step;
                strobe_d = 1'b1;
                if (next_step == '0) begin
                    active_d  = pattern_load ? load_word : pending_q ? shadow_q : active_q;
                    pending_d = 1'b0;
                end
            end
        end
        hit     = strobe_d & active_d[step_d];
        accept  = (RETRIG != 0) || adsr_idle;
        start_d = hit & accept;
        drop_d  = hit & ~accept;
`ifdef DRUM_SEQ_ACCENT_EN
        sustain_d = !strobe_d ? sustain_q
                  : active_d[STEPS + int'(step_d)] ? sustain_accent : sustain_normal;
`endif
    end

    // sequencer state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEQ_IDLE;
            step_q    <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            start_q   <= 1'b0;
            strobe_q  <= 1'b0;
            drop_q    <= 1'b0;
`ifdef DRUM_SEQ_ACCENT_EN
            sustain_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            start_q   <= start_d;
            strobe_q  <= strobe_d;
            drop_q    <= drop_d;
`ifdef DRUM_SEQ_ACCENT_EN
            sustain_q <= sustain_d;
`endif
        end
    end

    assign start       = start_q;
    assign step        = step_q;
    assign step_strobe = strobe_q;
    assign hit_dropped = drop_q;
    assign running     = (state_q == SEQ_RUN);
`ifdef DRUM_SEQ_ACCENT_EN
    assign sustain_level_out = sustain_q;
`endif

endmodule
